// File: rtl/mm_vector_feeder_pkg.sv
// Package mm_pkg: shared defaults, index width, FSM state type and the
// issue tag that travels alongside the dot-product tree.
//   MM_BIT_WIDTH / MM_N / MM_TREE_LAT : default element width, matrix size,
//                                       tree latency
//   IDX_W                             : row/column index width
//   mm_feed_state_t                   : feeder FSM states
//   mm_tag_t                          : {valid, row, col} issue tag
package mm_pkg;

    localparam int MM_BIT_WIDTH = 8;
    localparam int MM_N         = 4;
    localparam int MM_TREE_LAT  = 3;
    localparam int IDX_W        = $clog2(MM_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mm_feed_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } mm_tag_t;

endpackage

// File: rtl/mm_vector_feeder_if.sv
// Interface mm_vector_feeder_if: operand load port, run control, issue bus
// towards the dot-product tree, tree result input and tagged result stream.
//   slave  : the feeder (mm_vector_feeder)
//   master : the environment driving loads/start and returning tree output
// Optional macro MM_ISSUE_STALL_EN adds the 1-bit `stall` input.
//
// Handshake semantics: there is no backpressure anywhere. ld_valid is a
// one-cycle write strobe, taken only while the feeder is IDLE. vec_valid
// and res_valid are pure valid qualifiers: the consumer must take the data
// in the cycle it is valid. start is a one-cycle request, taken only in IDLE.
interface mm_vector_feeder_if
    import mm_pkg::*;
#(
    parameter int BIT_WIDTH = MM_BIT_WIDTH,
    parameter int N         = MM_N
);

`ifdef MM_ISSUE_STALL_EN
    logic                   stall;
`endif
    logic                   ld_valid;
    logic                   ld_sel;
    logic [IDX_W-1:0]       ld_idx;
    logic [BIT_WIDTH*N-1:0] ld_data;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   vec_valid;
    logic [BIT_WIDTH*N-1:0] A_vec;
    logic [BIT_WIDTH*N-1:0] B_vec;
    logic [BIT_WIDTH-1:0]   c_in;
    logic                   res_valid;
    logic [IDX_W-1:0]       res_row;
    logic [IDX_W-1:0]       res_col;
    logic [BIT_WIDTH-1:0]   res_data;
    mm_feed_state_t         state_dbg;

    modport slave (
`ifdef MM_ISSUE_STALL_EN
        input  stall,
`endif
        input  ld_valid, ld_sel, ld_idx, ld_data, start, c_in,
        output busy, done, vec_valid, A_vec, B_vec,
        output res_valid, res_row, res_col, res_data, state_dbg
    );

    modport master (
`ifdef MM_ISSUE_STALL_EN
        output stall,
`endif
        output ld_valid, ld_sel, ld_idx, ld_data, start, c_in,
        input  busy, done, vec_valid, A_vec, B_vec,
        input  res_valid, res_row, res_col, res_data, state_dbg
    );

endinterface

// File: rtl/mm_vector_feeder_tag_pipe.sv
// Module mm_tag_pipe: TREE_LAT-stage shift register carrying the issue tag
// so it lines up with the tree output. Shifts every cycle, whatever the
// feeder state, so bubbles travel through like any other entry.
//   clk, rst    : clock, async active-low reset (clears every stage)
//   tag_in      : tag of the pair issued this cycle (valid=0 for a bubble)
//   tag_out     : tag matching the tree output in this cycle
//   drain_empty : after the next shift the pipe holds no valid tag
module mm_tag_pipe
    import mm_pkg::*;
#(
    parameter int TREE_LAT = MM_TREE_LAT
) (
    input  logic    clk,
    input  logic    rst,
    input  mm_tag_t tag_in,
    output mm_tag_t tag_out,
    output logic    drain_empty
);

    mm_tag_t stage [TREE_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TREE_LAT; k++) stage[k] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int k = 1; k < TREE_LAT; k++) stage[k] <= stage[k-1];
        end
    end

    assign tag_out = stage[TREE_LAT-1];

    // The last stage is being consumed this cycle, so only the earlier
    // stages decide whether anything is still in flight after this edge.
    always_comb begin
        drain_empty = 1'b1;
        for (int k = 0; k < TREE_LAT - 1; k++) begin
            if (stage[k].valid) drain_empty = 1'b0;
        end
    end

endmodule

// File: rtl/mm_vector_feeder.sv
// Module mm_vector_feeder: holds one NxN A matrix (rows) and one NxN B
// matrix (columns), issues every (row i, col j) pair to the N-lane
// dot-product tree one per clock in row-major order, and re-tags the tree
// output as a (row, col, value) result stream with a done pulse.
//   clk, rst : clock, async active-low reset
//   bus      : mm_vector_feeder_if.slave (loads, start, issue bus, c_in,
//              results, busy/done, state_dbg)
// Optional macro MM_ISSUE_STALL_EN: bus.stall pauses issue during ISSUE.
module mm_vector_feeder
    import mm_pkg::*;
#(
    parameter int BIT_WIDTH = MM_BIT_WIDTH,
    parameter int N         = MM_N,
    parameter int TREE_LAT  = MM_TREE_LAT
) (
    input logic               clk,
    input logic               rst,
    mm_vector_feeder_if.slave bus
);

    localparam int               VW       = BIT_WIDTH * N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    mm_feed_state_t   state_q, state_d;
    logic [IDX_W-1:0] i_q, j_q, i_d, j_d;
    logic [VW-1:0]    a_buf [N];
    logic [VW-1:0]    b_buf [N];
    logic             stall_w;
    logic             issue;
    logic             drain_empty;
    mm_tag_t          tag_in, tag_out;

`ifdef MM_ISSUE_STALL_EN
    assign stall_w = bus.stall;
`else
    assign stall_w = 1'b0;
`endif

    // Operand buffers: writable only while idle. A write in the same cycle
    // as start lands before the first issue reads the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                a_buf[k] <= '0;
                b_buf[k] <= '0;
            end
        end else if (state_q == IDLE && bus.ld_valid) begin
            if (bus.ld_sel) b_buf[bus.ld_idx] <= bus.ld_data;
            else            a_buf[bus.ld_idx] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign issue = (state_q == ISSUE) && !stall_w;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            ISSUE: begin
                if (issue) begin
                    // N is a power of two, so the counters wrap to 0 on their own.
                    j_d = j_q + 1'b1;
                    if (j_q == LAST_IDX) begin
                        i_d = i_q + 1'b1;
                        if (i_q == LAST_IDX) state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_empty) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.vec_valid = issue;
    assign bus.A_vec     = issue ? a_buf[i_q] : '0;
    assign bus.B_vec     = issue ? b_buf[j_q] : '0;
    assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.state_dbg = state_q;

    // A stalled cycle pushes a bubble (valid=0) into the tag pipe.
    assign tag_in = '{valid: issue, row: i_q, col: j_q};

    mm_tag_pipe #(
        .TREE_LAT(TREE_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .tag_in     (tag_in),
        .tag_out    (tag_out),
        .drain_empty(drain_empty)
    );

    assign bus.res_valid = tag_out.valid;
    assign bus.res_row   = tag_out.row;
    assign bus.res_col   = tag_out.col;
    assign bus.res_data  = tag_out.valid ? bus.c_in : '0;

endmodule
